// File: rtl/rr_shift_pkg.sv
// rtl/rr_shift_pkg.sv - shared types and constants for the pipelined right shifter (honours RR_SHIFTER_SRA_EN)
package rr_shift_pkg;

  localparam int DATA_W    = 64;
  localparam int SHAMT_W   = 6;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_ROR  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_RSVD = 2'b11
  } shift_op_e;

  // Payload held in each pipeline register; the sign bit only exists when SRA is built
  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [SHAMT_W-1:0]   shamt;
    shift_op_e            op;
`ifdef RR_SHIFTER_SRA_EN
    logic                 sign;
`endif
    logic [TAG_W_DEF-1:0] tag;
  } stage_t;

endpackage

// File: rtl/rr_shifter_pipe_if.sv
// rtl/rr_shifter_pipe_if.sv - valid/ready handshake bundle for the pipelined right shifter
interface rr_shift_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [5:0]        in_shamt;
  logic [1:0]        in_op;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rr_shifter_pipe_stage_rr.sv
// rtl/rr_shifter_pipe_stage_rr.sv - one combinational right-shift stage of width SHAMT (honours RR_SHIFTER_SRA_EN)
module stage_rr
  import rr_shift_pkg::*;
#(
  parameter int SHAMT = 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              en_i,
  input  shift_op_e         op_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] data_o
);

  logic [SHAMT-1:0] fill;

  // Select the bits entering at the top, then shift by SHAMT when enabled
  always_comb begin
    fill = '0;
    if (op_i == OP_ROR) begin
      fill = data_i[SHAMT-1:0];
    end
`ifdef RR_SHIFTER_SRA_EN
    else if (op_i == OP_SRA) begin
      fill = {SHAMT{sign_i}};
    end
`endif
    data_o = en_i ? {fill, data_i[DATA_W-1:SHAMT]} : data_i;
  end

`ifndef RR_SHIFTER_SRA_EN
  logic unused_sign;
  assign unused_sign = sign_i;
`endif

endmodule

// File: rtl/rr_shifter_pipe.sv
// rtl/rr_shifter_pipe.sv - three-register valid/ready pipelined 64-bit right shifter (honours RR_SHIFTER_SRA_EN)
module rr_shifter_pipe #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_shift_if.slave  bus
);
  import rr_shift_pkg::*;

  logic   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  stage_t r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic   rdy1, rdy2, rdy3;

  logic [DATA_W-1:0] st1_data, st2_data, st4_data, st8_data, st16_data, st32_data;
  logic              sign_in, sign_r1, sign_r2;
  shift_op_e         in_op_e;
  logic              unused_bits;

  assign in_op_e = shift_op_e'(bus.in_op);

  // The operand's original sign travels with the transaction so later stages never re-sample it
`ifdef RR_SHIFTER_SRA_EN
  assign sign_in = bus.in_data[DATA_W-1];
  assign sign_r1 = r1_q.sign;
  assign sign_r2 = r2_q.sign;
`else
  assign sign_in = 1'b0;
  assign sign_r1 = 1'b0;
  assign sign_r2 = 1'b0;
`endif

  stage_rr #(.SHAMT(1))  u_st1  (.data_i(bus.in_data), .en_i(bus.in_shamt[0]), .op_i(in_op_e), .sign_i(sign_in), .data_o(st1_data));
  stage_rr #(.SHAMT(2))  u_st2  (.data_i(st1_data),    .en_i(bus.in_shamt[1]), .op_i(in_op_e), .sign_i(sign_in), .data_o(st2_data));
  stage_rr #(.SHAMT(4))  u_st4  (.data_i(r1_q.data),   .en_i(r1_q.shamt[2]),   .op_i(r1_q.op), .sign_i(sign_r1), .data_o(st4_data));
  stage_rr #(.SHAMT(8))  u_st8  (.data_i(st4_data),    .en_i(r1_q.shamt[3]),   .op_i(r1_q.op), .sign_i(sign_r1), .data_o(st8_data));
  stage_rr #(.SHAMT(16)) u_st16 (.data_i(r2_q.data),   .en_i(r2_q.shamt[4]),   .op_i(r2_q.op), .sign_i(sign_r2), .data_o(st16_data));
  stage_rr #(.SHAMT(32)) u_st32 (.data_i(st16_data),   .en_i(r2_q.shamt[5]),   .op_i(r2_q.op), .sign_i(sign_r2), .data_o(st32_data));

  // Backward ready chain: a stage can load if it is empty or its successor can load
  always_comb begin
    rdy3 = !v3_q || bus.out_ready;
    rdy2 = !v2_q || rdy3;
    rdy1 = !v1_q || rdy2;
  end

  // Next-state for each register: load from predecessor when ready, otherwise hold
  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    r1_d = r1_q;
    r2_d = r2_q;
    r3_d = r3_q;
    if (rdy1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        r1_d.data  = st2_data;
        r1_d.shamt = bus.in_shamt;
        r1_d.op    = in_op_e;
`ifdef RR_SHIFTER_SRA_EN
        r1_d.sign  = bus.in_data[DATA_W-1];
`endif
        r1_d.tag   = bus.in_tag;
      end
    end
    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        r2_d      = r1_q;
        r2_d.data = st8_data;
      end
    end
    if (rdy3) begin
      v3_d = v2_q;
      if (v2_q) begin
        r3_d      = r2_q;
        r3_d.data = st32_data;
      end
    end
  end

  // Pipeline registers; reset clears every field so no stale result can surface
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      r3_q <= r3_d;
    end
  end

  assign bus.in_ready  = rdy1;
  assign bus.out_valid = v3_q;
  assign bus.out_data  = r3_q.data;
  assign bus.out_tag   = r3_q.tag;

  // Shift-amount bits already consumed and fields that only matter upstream
  assign unused_bits = ^{r1_q.shamt[1:0], r2_q.shamt[3:0], r3_q.shamt, r3_q.op
`ifdef RR_SHIFTER_SRA_EN
                         , r3_q.sign
`endif
                        };

endmodule

// File: doc/rr_shifter_pipe.md
# rr_shifter_pipe

Pipelined 64-bit right shifter. It is the right-direction counterpart of the team's combinational rotate-left shifter and supports rotate-right, logical-right and arithmetic-right shifts. It decomposes the shift into six power-of-two stages (1, 2, 4, 8, 16, 32), registers after every second stage, and moves transactions through a valid/ready pipeline with per-stage bubble collapse. It sits on the ALU result path wherever a right shift must close timing at full clock rate.

## Interface
Parameters:
- DATA_W, 64, operand width; fixed at 64 because the six stages cover shift amounts 0..63
- TAG_W, 4, width of the opaque tag carried alongside each operand

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous and active-low
- in_valid  in  1  upstream offers a transaction
- in_ready  out  1  pipeline accepts a transaction this cycle
- in_data  in  DATA_W  operand
- in_shamt  in  6  shift amount
- in_op  in  2  shift operation: 00 ROR, 01 SRL, 10 SRA, 11 reserved
- in_tag  in  TAG_W  tag, passed through unchanged
- out_valid  out  1  a result is presented
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_W  shifted result
- out_tag  out  TAG_W  tag of the presented result

## Operation
- Register stages R1, R2 and R3. Each holds valid, data, remaining shamt bits, op and tag.
  - R1 captures the input after the 1 and 2 stages.
  - R2 captures R1 after the 4 and 8 stages.
  - R3 captures R2 after the 16 and 32 stages.
  - R3 drives out_*.
- Stage k shifts right by 2^k when shamt[k]=1 and passes data unchanged otherwise.
- Bits vacated at the top of the word are filled as follows:
  - ROR: the bits shifted out at the bottom.
  - SRL: 0.
  - SRA: the sign bit of the original operand. The sign bit is carried with the transaction, not re-sampled at each stage.
- Reserved op 11 behaves exactly as SRL.
- Ready chain:
  - rdy3 = !v3 | out_ready
  - rdy2 = !v2 | rdy3
  - rdy1 = !v1 | rdy2
  - in_ready = rdy1
  - The chain is combinational. No combinational path runs from in_valid to in_ready.
- Rk loads from its predecessor when rdyk=1. The loaded valid equals the predecessor's valid: in_valid for R1, v(k-1) otherwise.
- Rk holds its contents when rdyk=0.
- in_* is sampled only when in_valid & in_ready. out_data/out_tag are stable while out_valid & !out_ready.
- Boundary cases:
  - in_shamt=0: out_data = in_data for every op.
  - in_shamt=63 with ROR: result equals rotate-left by 1.
  - A bubble in any stage is collapsed when a later stage is stalled.

## Timing
- Latency: an input accepted at edge T appears with out_valid=1 after edge T+2, i.e. 3 register stages.
- Throughput: 1 transaction/cycle when out_ready is held high.
- Full pipeline: 3 transactions in flight. With out_ready=0 and all valids set, in_ready=0.
- Simultaneous drain and fill: when out_ready=1 and the pipe is full, in_ready=1 in the same cycle.
- Reset values while rst_n=0 at a rising edge:
  - v1, v2, v3 = 0
  - all data, shamt, op and tag registers = 0
  - therefore out_valid=0, out_data=0, out_tag=0
  - in_ready=1 in the first cycle after reset
- Reset mid-operation discards all in-flight transactions. No partial results are emitted.

## Configuration
- RR_SHIFTER_SRA_EN defined: op 10 performs an arithmetic shift with sign fill, as above.
- RR_SHIFTER_SRA_EN undefined:
  - No sign-fill logic or sign-carry register is built.
  - op 10 behaves exactly as SRL.
  - All other behaviour and timing are unchanged.

## Structure
- Package rr_shift_pkg holds:
  - shift_op_e enum (OP_ROR=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_RSVD=2'b11)
  - DATA_W=64 and SHAMT_W=6 constants
  - the pipeline-stage struct typedef (data, shamt, op, sign, tag)
- Sub-module stage_rr: one combinational stage with parameter SHAMT (1..32). Inputs are data, enable, op and sign; output is the shifted data. It is instantiated six times.
- The top holds the R1–R3 registers and the ready chain.

## Test plan
- Reset, then ROR with in_data=0x0000_0000_0000_0001, shamt=1 → out_data=0x8000_0000_0000_0000, out_valid exactly 3 cycles after acceptance, tag echoed.
- SRA with in_data=0x8000_0000_0000_0000, shamt=63:
  - RR_SHIFTER_SRA_EN defined → 0xFFFF_FFFF_FFFF_FFFF.
  - RR_SHIFTER_SRA_EN undefined → 0x0000_0000_0000_0001.
- SRL and reserved op 11 with in_data=0xF0F0_0000_0000_000F, shamt=4 → 0x0F0F_0000_0000_0000 for both; shamt=0 with each op → input unchanged.
- Back-to-back stream of 8 transactions with out_ready=0 for cycles 2–6:
  - in_ready drops after 3 accepts.
  - No loss or duplication; outputs in order with matching tags.
  - out_data stable while stalled.
- rst_n asserted with 3 transactions in flight → next cycle out_valid=0, out_data=0, in_ready=1; no stale result appears afterwards.
- Random ROR sweep over all shamt 0..63 against the reference model rotate-right; additionally check that ROR by s equals rotate-left by (64-s) mod 64.
